vga_term_ctrl: RTL and testbench

- Terminal-style write controller for the 80x35 debug text screen buffer.
- Accepts ASCII bytes over a valid/ready stream and tracks a cursor.
- Handles CR, LF, backspace and line wrap, and sequences whole-screen and single-line clears.
- Drives the write port of the character RAM that the VGA symbol/pixel generator reads at address disp_y + disp_x, i.e. row*80 + col.

---
 rtl/vga_term_pkg.sv | 18 +
 rtl/vga_term_cursor.sv | 70 +++++++
 rtl/vga_term_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vga_term_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_term_pkg.sv
// Shared types and constants for the debug text terminal write controller.
package vga_term_pkg;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 35;

endpackage

// File: rtl/vga_term_cursor.sv
// Cursor position tracker; row_base follows cur_y*COLS incrementally so no multiplier is needed.
module vga_term_cursor
  import vga_term_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              home,
  input  logic              newline,
  input  logic              cr,
  input  logic              dec,
  input  logic              inc,
  output logic [6:0]        cur_x,
  output logic [5:0]        cur_y,
  output logic [ADDR_W-1:0] row_base
);

  localparam logic [5:0]        LAST_ROW = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [6:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic [ADDR_W-1:0] rb_q, rb_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    rb_d = rb_q;
    if (home) begin
      x_d  = '0;
      y_d  = '0;
      rb_d = '0;
    end else if (newline) begin
      x_d = '0;
      if (y_q == LAST_ROW) begin
        y_d  = '0;
        rb_d = '0;
      end else begin
        y_d  = y_q + 6'd1;
        rb_d = rb_q + ROW_STEP;
      end
    end else if (cr) begin
      x_d = '0;
    end else if (dec) begin
      x_d = x_q - 7'd1;
    end else if (inc) begin
      x_d = x_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q  <= '0;
      y_q  <= '0;
      rb_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      rb_q <= rb_d;
    end
  end

  assign cur_x    = x_q;
  assign cur_y    = y_q;
  assign row_base = rb_q;

endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal-style write controller for the text screen buffer: byte stream in, registered RAM write port out.
module vga_term_ctrl
  import vga_term_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cur_x,
  output logic [5:0]        cur_y
);

  // One extra bit so the terminal count fits even when COLS*ROWS == 2**ADDR_W.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(COLS * ROWS);
  localparam logic [CNT_W-1:0] LINE     = CNT_W'(COLS);
  localparam logic [6:0]       LAST_COL = 7'(COLS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              home, newline, cr, dec, inc;
  logic [ADDR_W-1:0] row_base;
  logic              accept;

  assign in_ready = (state_q == IDLE) && !clear;
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    home      = 1'b0;
    newline   = 1'b0;
    cr        = 1'b0;
    dec       = 1'b0;
    inc       = 1'b0;

    if (clear) begin
      state_d = CLR_ALL;
      cnt_d   = '0;
      home    = 1'b1;
    end else begin
      unique case (state_q)
        CLR_ALL: begin
          if (cnt_q < TOTAL) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(cnt_q);
            wr_data_d = CLR_CHAR;
            cnt_d     = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end

        // row_base already points at the new row: the cursor moved on the accepting edge.
        CLR_LINE: begin
          if (cnt_q < LINE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + ADDR_W'(cnt_q);
            wr_data_d = CLR_CHAR;
            cnt_d     = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end

        IDLE: begin
          if (accept) begin
            if (in_data == CHR_CR) begin
              cr = 1'b1;
            end else if (in_data == CHR_LF) begin
              newline = 1'b1;
              state_d = CLR_LINE;
              cnt_d   = '0;
            end else if (in_data == CHR_BS) begin
              if (cur_x != '0) begin
                dec       = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = row_base + ADDR_W'(cur_x - 7'd1);
                wr_data_d = CLR_CHAR;
              end
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = row_base + ADDR_W'(cur_x);
              wr_data_d = in_data;
              if (cur_x == LAST_COL) begin
                newline = 1'b1;
                state_d = CLR_LINE;
                cnt_d   = '0;
              end else begin
                inc = 1'b1;
              end
            end
          end
        end

        default: begin
          state_d = CLR_ALL;
          cnt_d   = '0;
          home    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CLR_ALL;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  vga_term_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .resetn  (resetn),
    .home    (home),
    .newline (newline),
    .cr      (cr),
    .dec     (dec),
    .inc     (inc),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .row_base(row_base)
  );

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Scoreboard bench for vga_term_ctrl: expected buffer writes are queued by the stimulus, popped by a write monitor.
module tb_vga_term_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        busy;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [5:0]  cur_y;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb[$];
  wr_t exp_w;
  int  checks    = 0;
  int  failures  = 0;
  int  wr_seen   = 0;
  int  ready_bad = 0;

  vga_term_ctrl #(
    .COLS    (80),
    .ROWS    (35),
    .ADDR_W  (12),
    .CLR_CHAR(8'h20)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .clear   (clear),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cur_x   (cur_x),
    .cur_y   (cur_y)
  );

  always #5 clk = ~clk;

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && wr_en) begin
      wr_seen++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if (wr_addr !== exp_w.a || wr_data !== exp_w.d) begin
          failures++;
          $display("FAIL wr_match: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, exp_w.a, exp_w.d);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_w(input int a, input int d);
    wr_t w;
    w.a = 12'(a);
    w.d = 8'(d);
    sb.push_back(w);
  endtask

  task automatic push_line(input int row);
    for (int c = 0; c < 80; c++) push_w(row * 80 + c, 8'h20);
  endtask

  task automatic push_screen();
    for (int i = 0; i < 2800; i++) push_w(i, 8'h20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for the controller to go idle with every expected write observed.
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      #1;
      if (busy && in_ready) ready_bad++;
      if (!busy && sb.size() == 0) break;
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
    end
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    #22;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);

    push_screen();
    @(negedge clk);
    resetn = 1'b1;
    wait_idle(4000);
    chk("init_writes", wr_seen, 2800);
    chk("init_busy", int'(busy), 0);
    chk("init_ready", int'(in_ready), 1);

    push_w(0, 8'h41);
    send_byte(8'h41);
    push_w(1, 8'h42);
    send_byte(8'h42);
    wait_idle(100);
    chk("ab_cur_x", int'(cur_x), 2);
    chk("ab_cur_y", int'(cur_y), 0);

    push_line(1);
    send_byte(8'h0A);
    wait_idle(200);
    push_line(2);
    send_byte(8'h0A);
    wait_idle(200);
    for (int i = 0; i < 5; i++) begin
      push_w(160 + i, 8'h61 + i);
      send_byte(8'(8'h61 + i));
    end
    wait_idle(100);
    chk("pre_bs_cur_x", int'(cur_x), 5);
    chk("pre_bs_cur_y", int'(cur_y), 2);

    push_w(164, 8'h20);
    send_byte(8'h08);
    wait_idle(100);
    chk("bs_cur_x", int'(cur_x), 4);
    send_byte(8'h0D);
    wait_idle(100);
    chk("cr_cur_x", int'(cur_x), 0);
    send_byte(8'h0D);
    wait_idle(100);
    chk("cr0_cur_x", int'(cur_x), 0);
    send_byte(8'h08);
    wait_idle(100);
    chk("bs0_cur_x", int'(cur_x), 0);
    chk("bs0_cur_y", int'(cur_y), 2);

    for (int r = 3; r < 35; r++) begin
      push_line(r);
      send_byte(8'h0A);
      wait_idle(200);
    end
    chk("row34_cur_y", int'(cur_y), 34);

    ready_bad = 0;
    push_line(0);
    send_byte(8'h0A);
    wait_idle(200);
    chk("wrap_ready_low", ready_bad, 0);
    chk("wrap_cur_x", int'(cur_x), 0);
    chk("wrap_cur_y", int'(cur_y), 0);

    for (int i = 0; i < 80; i++) begin
      push_w(i, 8'h21 + i);
      if (i == 79) push_line(1);
      send_byte(8'(8'h21 + i));
    end
    wait_idle(300);
    chk("autonl_cur_x", int'(cur_x), 0);
    chk("autonl_cur_y", int'(cur_y), 1);

    push_line(2);
    send_byte(8'h0A);
    repeat (10) @(negedge clk);
    #1;
    chk("mid_line_busy", int'(busy), 1);
    sb.delete();
    push_screen();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    chk("clr_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", int'(busy), 1);
    chk("clr_cur_x", int'(cur_x), 0);
    chk("clr_cur_y", int'(cur_y), 0);
    wait_idle(4000);
    chk("clr_done_ready", int'(in_ready), 1);
    chk("clr_done_cur_y", int'(cur_y), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
